// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay timer and other PWM-path timers.
package delay_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_DELAY_CYCLES = 20000;

  // A zero delay is never loaded: fall back to the default, or to a single tick.
  function automatic int unsigned effective_delay(input int unsigned delay,
                                                  input logic        use_default,
                                                  input int unsigned default_delay);
    if (delay != 0)  return delay;
    if (use_default) return default_delay;
    return 1;
  endfunction

endpackage

// File: rtl/delay_prescaler.sv
// Reloadable tick prescaler: tick_o is high whenever the count is zero,
// after which the count reloads from the latched period.
module delay_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] reload_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [PRESCALE_W-1:0] period_q, period_d;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    psc_d    = psc_q;
    period_d = period_q;
    if (clear_i) begin
      psc_d    = '0;
      period_d = '0;
    end else if (load_i) begin
      psc_d    = reload_i;
      period_d = reload_i;
    end else if (psc_q == '0) begin
      psc_d = period_q;
    end else begin
      psc_d = psc_q - PRESCALE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      psc_q    <= '0;
      period_q <= '0;
    end else begin
      psc_q    <= psc_d;
      period_q <= period_d;
    end
  end

  assign tick_o = (psc_q == '0);

endmodule

// File: rtl/delay_timer.sv
// Retriggerable delay timer with run-time delay/prescale, one-shot or
// periodic operation, abort and remaining-count visibility.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int unsigned WIDTH         = 15,
  parameter int unsigned PRESCALE_W    = 8,
  parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  periodic_i,
  input  logic                  use_default_i,
  input  logic [WIDTH-1:0]      delay_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      remaining_o
);

  if (DEFAULT_DELAY == 0 || (DEFAULT_DELAY >> WIDTH) != 0) begin : g_bad_default
    $error("DEFAULT_DELAY must be nonzero and fit in WIDTH bits");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             psc_load, psc_clear, tick;
  logic [WIDTH-1:0] eff_delay;

  assign eff_delay = WIDTH'(effective_delay(32'(delay_i), use_default_i, DEFAULT_DELAY));

  delay_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .load_i   (psc_load),
    .clear_i  (psc_clear),
    .reload_i (prescale_i),
    .tick_o   (tick)
  );

  // Priority: abort, then (re)start, then counting; a start discards a same-edge terminal tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    psc_load   = 1'b0;
    psc_clear  = 1'b0;
    if (stop_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      psc_clear = 1'b1;
    end else if (start_i) begin
      state_d    = ST_RUN;
      cnt_d      = eff_delay;
      reload_d   = eff_delay;
      periodic_d = periodic_i;
      psc_load   = 1'b1;
    end else if (state_q == ST_RUN && tick) begin
      if (cnt_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (periodic_q) begin
          cnt_d = reload_q;
        end else begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          psc_clear = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = done_q;
  assign remaining_o = cnt_q;

endmodule

// File: tb/tb_delay_timer.sv
// Directed self-checking bench for delay_timer: one-shot, periodic, default
// delay, retrigger, abort priority and asynchronous reset.
module tb_delay_timer;

  localparam int unsigned WIDTH      = 15;
  localparam int unsigned PRESCALE_W = 8;

  logic                  clk;
  logic                  rst_ni;
  logic                  start_i;
  logic                  stop_i;
  logic                  periodic_i;
  logic                  use_default_i;
  logic [WIDTH-1:0]      delay_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic                  busy_o;
  logic                  done_o;
  logic [WIDTH-1:0]      remaining_o;

  int checks = 0;
  int errors = 0;

  delay_timer #(
    .WIDTH        (WIDTH),
    .PRESCALE_W   (PRESCALE_W),
    .DEFAULT_DELAY(20000)
  ) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .periodic_i   (periodic_i),
    .use_default_i(use_default_i),
    .delay_i      (delay_i),
    .prescale_i   (prescale_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .remaining_o  (remaining_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic busy, input logic done,
                           input logic [31:0] rem);
    check({tag, ".busy"}, 32'(busy_o), 32'(busy));
    check({tag, ".done"}, 32'(done_o), 32'(done));
    check({tag, ".rem"},  32'(remaining_o), rem);
  endtask

  // Present a start at the current negedge; returns after edge 0 has passed.
  task automatic do_start(input logic [WIDTH-1:0] d, input logic [PRESCALE_W-1:0] p,
                          input logic per, input logic use_def);
    delay_i       = d;
    prescale_i    = p;
    periodic_i    = per;
    use_default_i = use_def;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b1; start_i = 1'b0; stop_i = 1'b0; periodic_i = 1'b0;
    use_default_i = 1'b0; delay_i = '0; prescale_i = '0;
    #2 rst_ni = 1'b0;
    #1 check_out("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_out("idle", 1'b0, 1'b0, 0);

    // One-shot, D=5, P=0: done only after edge 5.
    do_start(15'd5, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_out($sformatf("os5.e%0d", k), 1'b1, 1'b0, 32'(5 - k));
      @(negedge clk);
    end
    check_out("os5.e5", 1'b0, 1'b1, 0);
    @(negedge clk);
    check_out("os5.e6", 1'b0, 1'b0, 0);

    // Periodic, D=3, P=2: pulses after edges 9 and 18; stop at edge 20.
    do_start(15'd3, 8'd2, 1'b1, 1'b0);
    for (int e = 0; e < 30; e++) begin
      check_out($sformatf("per.e%0d", e), e < 20, (e == 9) || (e == 18),
                (e < 20) ? 32'(3 - ((e % 9) / 3)) : 32'd0);
      if (e == 19) stop_i = 1'b1;
      if (e == 20) stop_i = 1'b0;
      @(negedge clk);
    end

    // Zero delay with default substitution: done after edge 20000.
    do_start(15'd0, 8'd0, 1'b0, 1'b1);
    check_out("def.e0", 1'b1, 1'b0, 20000);
    repeat (19999) @(negedge clk);
    check_out("def.e19999", 1'b1, 1'b0, 1);
    @(negedge clk);
    check_out("def.e20000", 1'b0, 1'b1, 0);
    @(negedge clk);

    // Zero delay without default: one tick.
    do_start(15'd0, 8'd0, 1'b0, 1'b0);
    check_out("one.e0", 1'b1, 1'b0, 1);
    @(negedge clk);
    check_out("one.e1", 1'b0, 1'b1, 0);
    @(negedge clk);

    // Retrigger: D=10 started, restarted at edge 6 with D=4 -> done after edge 10.
    do_start(15'd10, 8'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_out("rt.e5", 1'b1, 1'b0, 5);
    do_start(15'd4, 8'd0, 1'b0, 1'b0);
    for (int e = 6; e < 10; e++) begin
      check_out($sformatf("rt.e%0d", e), 1'b1, 1'b0, 32'(4 - (e - 6)));
      @(negedge clk);
    end
    check_out("rt.e10", 1'b0, 1'b1, 0);
    @(negedge clk);

    // Stop and start together on the terminal tick: abort wins, no done.
    do_start(15'd4, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_out("ab.e3", 1'b1, 1'b0, 1);
    stop_i  = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    stop_i  = 1'b0;
    start_i = 1'b0;
    check_out("ab.e4", 1'b0, 1'b0, 0);
    @(negedge clk);
    check_out("ab.e5", 1'b0, 1'b0, 0);

    // Asynchronous reset mid-count.
    do_start(15'd10, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_out("ar.e3", 1'b1, 1'b0, 7);
    #2 rst_ni = 1'b0;
    #1 check_out("ar.async", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_out($sformatf("ar.post%0d", k), 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
